// File: rtl/alu_pkg.sv
// Shared encodings, flag positions and type definitions for the sequential ALU.
// The opcode decoder lives here so the top and any future stage agree on op classes.
package alu_pkg;

   // Primary opcodes; OP_RR selects the register-register group keyed by opext.
   localparam logic [3:0] OP_RR    = 4'b0000;
   localparam logic [3:0] OP_ADDI  = 4'b0101;
   localparam logic [3:0] OP_ADDUI = 4'b0110;
   localparam logic [3:0] OP_ADDCI = 4'b0111;
   localparam logic [3:0] OP_LSHI  = 4'b1000;
   localparam logic [3:0] OP_SUBI  = 4'b1001;
   localparam logic [3:0] OP_GRP_A = 4'b1010;
   localparam logic [3:0] OP_CMPI  = 4'b1011;
   localparam logic [3:0] OP_MOVI  = 4'b1101;
   localparam logic [3:0] OP_RSHI  = 4'b1110;

   localparam logic [3:0] OPX_AND  = 4'b0001;
   localparam logic [3:0] OPX_OR   = 4'b0010;
   localparam logic [3:0] OPX_XOR  = 4'b0011;
   localparam logic [3:0] OPX_ADD  = 4'b0101;
   localparam logic [3:0] OPX_ADDU = 4'b0110;
   localparam logic [3:0] OPX_ADDC = 4'b0111;
   localparam logic [3:0] OPX_SUB  = 4'b1001;
   localparam logic [3:0] OPX_CMP  = 4'b1011;
   localparam logic [3:0] OPX_MOV  = 4'b1101;
   localparam logic [3:0] OPX_RSH  = 4'b1110;

   // Extensions under OP_GRP_A
   localparam logic [3:0] OPX_ALSH = 4'b0001;
   localparam logic [3:0] OPX_NOT  = 4'b0011;
   localparam logic [3:0] OPX_ARSH = 4'b0100;

   localparam int FLG_C = 4;
   localparam int FLG_L = 3;
   localparam int FLG_F = 2;
   localparam int FLG_Z = 1;
   localparam int FLG_N = 0;

   typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

   typedef enum logic [3:0] {
      K_NOP, K_ADD, K_ADDU, K_ADDC, K_SUB, K_CMP, K_AND, K_OR,
      K_XOR, K_NOT, K_MOV, K_LSH, K_RSH, K_ARSH, K_ALSH
   } op_kind_e;

   typedef enum logic [1:0] {SH_LEFT, SH_RIGHT, SH_ARITH} shift_mode_e;

   function automatic op_kind_e decode_op(input logic [3:0] op, input logic [3:0] ext);
      op_kind_e k;
      k = K_NOP;
      case (op)
         OP_RR: begin
            case (ext)
               OPX_AND:  k = K_AND;
               OPX_OR:   k = K_OR;
               OPX_XOR:  k = K_XOR;
               OPX_ADD:  k = K_ADD;
               OPX_ADDU: k = K_ADDU;
               OPX_ADDC: k = K_ADDC;
               OPX_SUB:  k = K_SUB;
               OPX_CMP:  k = K_CMP;
               OPX_MOV:  k = K_MOV;
               OPX_RSH:  k = K_RSH;
               default:  k = K_NOP;
            endcase
         end
         OP_GRP_A: begin
            case (ext)
               OPX_ALSH: k = K_ALSH;
               OPX_NOT:  k = K_NOT;
               OPX_ARSH: k = K_ARSH;
               default:  k = K_NOP;
            endcase
         end
         OP_ADDI:  k = K_ADD;
         OP_ADDUI: k = K_ADDU;
         OP_ADDCI: k = K_ADDC;
         OP_LSHI:  k = K_LSH;
         OP_SUBI:  k = K_SUB;
         OP_CMPI:  k = K_CMP;
         OP_MOVI:  k = K_MOV;
         OP_RSHI:  k = K_RSH;
         default:  k = K_NOP;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter: loads an operand and a magnitude, moves up to SHIFT_STEP bits
// per cycle, then holds done until the owner acknowledges the result.
module alu_shift_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         ack,
   input  logic [WIDTH-1:0]             a,
   input  logic [$clog2(WIDTH):0]       mag,
   input  shift_mode_e                  mode,
   output logic [WIDTH-1:0]             result,
   output logic                         done
);

   localparam int SHAMT_W = $clog2(WIDTH) + 1;
   localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(SHIFT_STEP);

   logic                running;
   logic [WIDTH-1:0]    work;
   logic [SHAMT_W-1:0]  rem;
   shift_mode_e         mode_q;
   logic [SHAMT_W-1:0]  step;
   logic [WIDTH-1:0]    shifted;

   // The final partial step only moves what is left.
   always_comb begin
      step    = (rem < STEP_MAX) ? rem : STEP_MAX;
      shifted = work;
      case (mode_q)
         SH_LEFT:  shifted = work << step;
         SH_RIGHT: shifted = work >> step;
         SH_ARITH: shifted = $unsigned($signed(work) >>> step);
         default:  shifted = work;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         work    <= '0;
         rem     <= '0;
         mode_q  <= SH_LEFT;
      end else if (start) begin
         running <= 1'b1;
         work    <= a;
         rem     <= mag;
         mode_q  <= mode;
      end else if (running) begin
         if (rem != '0) begin
            work <= shifted;
            rem  <= rem - step;
         end else if (ack) begin
            running <= 1'b0;
         end
      end
   end

   assign result = work;
   assign done   = running && (rem == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, a persistent CLFZN flag register
// and multi-cycle variable shifts delegated to alu_shift_unit.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int SHIFT_STEP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       opcode,
   input  logic [3:0]       opext,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic [4:0]       clfzn
);

   localparam int SHAMT_W = $clog2(WIDTH) + 1;
   localparam logic [SHAMT_W-1:0] SH_MAX = SHAMT_W'(WIDTH);

   // |k| clipped to WIDTH; the most negative k maps to its true magnitude as unsigned.
   function automatic logic [SHAMT_W-1:0] shift_mag(input logic signed [SHAMT_W-1:0] k);
      logic [SHAMT_W-1:0] m;
      m = k[SHAMT_W-1] ? $unsigned(-k) : $unsigned(k);
      if (m > SH_MAX) m = SH_MAX;
      return m;
   endfunction

   function automatic logic add_overflow(input logic sa, input logic sb, input logic sr);
      return (sa == sb) && (sr != sa);
   endfunction

   state_e                    state, state_n;
   op_kind_e                  kind;
   logic                      accept;
   logic                      is_shift;
   logic                      shift_start;
   logic                      sh_ack;
   logic                      sh_done;
   logic [WIDTH-1:0]          sh_result;
   shift_mode_e               sh_mode;
   logic signed [SHAMT_W-1:0] sh_k;
   logic [SHAMT_W-1:0]        sh_mag;
   logic                      cin;
   logic [WIDTH:0]            sum;
   logic [WIDTH:0]            diff;
   logic signed [WIDTH-1:0]   a_sgn, b_sgn;
   logic [WIDTH-1:0]          alu_s;
   logic [4:0]                flags_n;

   assign kind     = decode_op(opcode, opext);
   assign is_shift = (kind == K_LSH) || (kind == K_RSH) || (kind == K_ARSH) || (kind == K_ALSH);
   assign sh_k     = b[SHAMT_W-1:0];
   assign sh_mag   = shift_mag(sh_k);
   assign a_sgn    = a;
   assign b_sgn    = b;

   always_comb begin
      sh_mode = SH_LEFT;
      case (kind)
         K_LSH:   sh_mode = sh_k[SHAMT_W-1] ? SH_RIGHT : SH_LEFT;
         K_RSH:   sh_mode = SH_RIGHT;
         K_ARSH:  sh_mode = SH_ARITH;
         default: sh_mode = SH_LEFT;
      endcase
   end

   // Handshake FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n     = state;
      in_ready    = (state == ST_IDLE) && (!out_valid || out_ready);
      accept      = in_valid && in_ready;
      shift_start = accept && is_shift && (sh_mag != '0);
      sh_ack      = (state == ST_SHIFT) && sh_done && (!out_valid || out_ready);
      case (state)
         ST_IDLE:  if (shift_start) state_n = ST_SHIFT;
         ST_SHIFT: if (sh_ack) state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   alu_shift_unit #(
      .WIDTH      (WIDTH),
      .SHIFT_STEP (SHIFT_STEP)
   ) u_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (shift_start),
      .ack    (sh_ack),
      .a      (a),
      .mag    (sh_mag),
      .mode   (sh_mode),
      .result (sh_result),
      .done   (sh_done)
   );

   // Combinational arithmetic and next flags
   always_comb begin
      cin     = (kind == K_ADDC) ? clfzn[FLG_C] : 1'b0;
      sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      diff    = {1'b0, a} - {1'b0, b};
      alu_s   = '0;
      flags_n = clfzn;
      case (kind)
         K_ADD: begin
            alu_s          = sum[WIDTH-1:0];
            flags_n[FLG_F] = add_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            flags_n[FLG_Z] = (sum[WIDTH-1:0] == '0);
         end
         K_ADDU: begin
            alu_s          = sum[WIDTH-1:0];
            flags_n[FLG_C] = sum[WIDTH];
            flags_n[FLG_Z] = (sum[WIDTH-1:0] == '0);
         end
         K_ADDC: begin
            alu_s          = sum[WIDTH-1:0];
            flags_n[FLG_C] = sum[WIDTH];
            flags_n[FLG_F] = add_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            flags_n[FLG_Z] = (sum[WIDTH-1:0] == '0);
         end
         K_SUB: begin
            alu_s          = diff[WIDTH-1:0];
            flags_n[FLG_C] = diff[WIDTH];
            flags_n[FLG_F] = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            flags_n[FLG_Z] = (diff[WIDTH-1:0] == '0);
         end
         K_CMP: begin
            alu_s          = s;
            flags_n[FLG_Z] = (a == b);
            flags_n[FLG_L] = (a < b);
            flags_n[FLG_N] = (a_sgn < b_sgn);
         end
         K_AND:  alu_s = a & b;
         K_OR:   alu_s = a | b;
         K_XOR:  alu_s = a ^ b;
         K_NOT:  alu_s = ~a;
         K_MOV:  alu_s = b;
         K_LSH, K_RSH, K_ARSH, K_ALSH: alu_s = a;
         default: alu_s = '0;
      endcase
   end

   // Result and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s         <= '0;
         out_valid <= 1'b0;
         clfzn     <= '0;
      end else if (accept && !shift_start) begin
         s         <= alu_s;
         out_valid <= 1'b1;
         clfzn     <= flags_n;
      end else if (shift_start) begin
         out_valid <= 1'b0;
      end else if (sh_ack) begin
         s         <= sh_result;
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
